// File: rtl/simon_key_expander.sv
// ---------------------------------------------------------------------------
// simon_key_expander
// Sequential SIMON key schedule. A master key of M words (N bits each) is
// loaded, and round keys k[0..T-1] are then presented one at a time on a
// valid/ready interface. The default instance is SIMON64/96.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   key_in    master key, key_in[N-1:0] = k[0], top word = k[M-1]
//   key_load  start request, only honoured while idle
//   busy      high while round keys are being produced
//   rk_out    current round key k[rk_idx]
//   rk_idx    index of rk_out
//   rk_valid  rk_out / rk_idx are valid
//   rk_ready  consumer accepts the current round key
//   done      one-cycle pulse after the last round key is accepted
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for key_load, outputs quiet
// S_RUN  | presenting k[rk_idx], advance on each handshake
// S_DONE | last key accepted, done high for this single cycle
// ---------------------------------------------------------------------------
module simon_key_expander #(
   parameter int          N    = 32,
   parameter int          M    = 3,
   parameter int          T    = 42,
   parameter logic [61:0] ZSEQ = 62'b10101111011100000011010010011000101000010001111110010110110011,
   localparam int         IW   = $clog2(T)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*M-1:0] key_in,
   input  logic           key_load,
   output logic           busy,
   output logic [N-1:0]   rk_out,
   output logic [IW-1:0]  rk_idx,
   output logic           rk_valid,
   input  logic           rk_ready,
   output logic           done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       state;
   // win[0] is the key currently presented; win[M-1] is the newest word
   logic [N-1:0] win [M];
   logic [5:0]   zc;
   logic [N-1:0] tmp_a;
   logic [N-1:0] tmp_b;
   logic [N-1:0] knew;
   logic         z_bit;
   logic         hs;

   // next schedule word from the current window
   always_comb begin
      tmp_a = {win[M-1][2:0], win[M-1][N-1:3]};
      if (M == 4) begin
         tmp_a = tmp_a ^ win[1];
      end
      tmp_b = tmp_a ^ {tmp_a[0], tmp_a[N-1:1]};
      // the z constant is stored with z[0] in the MSB
      z_bit = ZSEQ[6'd61 - zc];
      knew  = ~win[0] ^ tmp_b ^ N'(3) ^ N'(z_bit);
   end

   assign hs     = rk_valid & rk_ready;
   assign rk_out = win[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         done     <= 1'b0;
         rk_idx   <= '0;
         zc       <= '0;
         for (int j = 0; j < M; j++) begin
            win[j] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (key_load) begin
                  for (int j = 0; j < M; j++) begin
                     win[j] <= key_in[j*N +: N];
                  end
                  rk_idx   <= '0;
                  zc       <= '0;
                  rk_valid <= 1'b1;
                  busy     <= 1'b1;
                  state    <= S_RUN;
               end
            end

            S_RUN: begin
               if (hs) begin
                  for (int j = 0; j < M-1; j++) begin
                     win[j] <= win[j+1];
                  end
                  win[M-1] <= knew;
                  zc       <= (zc == 6'd61) ? 6'd0 : zc + 6'd1;
                  rk_idx   <= rk_idx + IW'(1);
                  if (rk_idx == IW'(T-1)) begin
                     rk_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               // key_load is deliberately not looked at here
               done  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simon_key_expander.sv
// ---------------------------------------------------------------------------
// tb_simon_key_expander
// Checks the SIMON key expander in two configurations: SIMON64/96 (default
// parameters) and SIMON32/64. A behavioural model computes the full round key
// list from the master key with the textbook schedule formula, tracks the
// load / handshake / done protocol, and is compared against both DUTs on
// every falling edge. Literal expectations and the published cipher test
// vectors pin the model itself.
// ---------------------------------------------------------------------------
module tb_simon_key_expander;

   localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

   logic        clk;
   logic        rst;

   logic [95:0] a_key;
   logic        a_load, a_ready, a_busy, a_valid, a_done;
   logic [31:0] a_out;
   logic [5:0]  a_idx;

   logic [63:0] b_key;
   logic        b_load, b_ready, b_busy, b_valid, b_done;
   logic [15:0] b_out;
   logic [4:0]  b_idx;

   int n_checks = 0;
   int n_fail   = 0;
   bit model_on = 1'b0;

   simon_key_expander u_a (
      .clk      (clk),
      .rst      (rst),
      .key_in   (a_key),
      .key_load (a_load),
      .busy     (a_busy),
      .rk_out   (a_out),
      .rk_idx   (a_idx),
      .rk_valid (a_valid),
      .rk_ready (a_ready),
      .done     (a_done)
   );

   simon_key_expander #(.N(16), .M(4), .T(32), .ZSEQ(Z0)) u_b (
      .clk      (clk),
      .rst      (rst),
      .key_in   (b_key),
      .key_load (b_load),
      .busy     (b_busy),
      .rk_out   (b_out),
      .rk_idx   (b_idx),
      .rk_valid (b_valid),
      .rk_ready (b_ready),
      .done     (b_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- model ----------------
   int          mn [2] = '{32, 16};
   int          mm [2] = '{3, 4};
   int          mt [2] = '{42, 32};
   logic [63:0] mkeys [2][64];
   int          m_state [2] = '{0, 0};   // 0 idle, 1 producing keys, 2 done pulse
   bit          m_valid [2] = '{0, 0};
   bit          m_busy  [2] = '{0, 0};
   bit          m_done  [2] = '{0, 0};
   int          m_idx   [2] = '{0, 0};

   function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
      logic [63:0] mask;
      mask = (64'd1 << n) - 64'd1;
      return ((x >> r) | (x << (n - r))) & mask;
   endfunction

   function automatic logic [63:0] rol(input logic [63:0] x, input int r, input int n);
      return ror(x, n - r, n);
   endfunction

   task automatic gen_keys(input int d, input logic [127:0] key);
      int          n;
      int          m;
      logic [63:0] mask;
      logic [63:0] tmp;
      logic [61:0] z;
      n    = mn[d];
      m    = mm[d];
      z    = (d == 0) ? Z2 : Z0;
      mask = (64'd1 << n) - 64'd1;
      for (int i = 0; i < 64; i++) begin
         if (i < m) begin
            mkeys[d][i] = 64'(key >> (i * n)) & mask;
         end else begin
            tmp = ror(mkeys[d][i-1], 3, n);
            if (m == 4) tmp = tmp ^ mkeys[d][i-3];
            tmp = tmp ^ ror(tmp, 1, n);
            mkeys[d][i] = (~mkeys[d][i-m] ^ tmp ^ 64'd3 ^ 64'(z[61 - ((i - m) % 62)])) & mask;
         end
      end
   endtask

   // SIMON encryption with the model's round keys, used to pin the schedule
   function automatic logic [63:0] encrypt(input int d, input logic [63:0] pt);
      int          n;
      logic [63:0] mask, x, y, t;
      n    = mn[d];
      mask = (64'd1 << n) - 64'd1;
      x    = (pt >> n) & mask;
      y    = pt & mask;
      for (int i = 0; i < mt[d]; i++) begin
         t = x;
         x = (y ^ (rol(x, 1, n) & rol(x, 8, n)) ^ rol(x, 2, n) ^ mkeys[d][i]) & mask;
         y = t;
      end
      return (x << n) | y;
   endfunction

   task automatic model_step(input int d, input logic r, input logic ld, input logic rdy,
                             input logic [127:0] key);
      if (r) begin
         m_state[d] = 0;
         m_valid[d] = 0;
         m_busy[d]  = 0;
         m_done[d]  = 0;
         m_idx[d]   = 0;
      end else begin
         case (m_state[d])
            0: begin
               m_done[d] = 0;
               if (ld) begin
                  gen_keys(d, key);
                  m_state[d] = 1;
                  m_valid[d] = 1;
                  m_busy[d]  = 1;
                  m_idx[d]   = 0;
               end
            end
            1: begin
               if (rdy) begin
                  if (m_idx[d] == mt[d] - 1) begin
                     m_state[d] = 2;
                     m_valid[d] = 0;
                     m_busy[d]  = 0;
                     m_done[d]  = 1;
                  end else begin
                     m_idx[d] = m_idx[d] + 1;
                  end
               end
            end
            default: begin
               m_state[d] = 0;
               m_done[d]  = 0;
            end
         endcase
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic check_dut(input int d, input logic busy, input logic valid, input logic done,
                            input int idx, input logic [63:0] out);
      chk($sformatf("dut%0d_busy", d),  64'(busy),  64'(m_busy[d]));
      chk($sformatf("dut%0d_valid", d), 64'(valid), 64'(m_valid[d]));
      chk($sformatf("dut%0d_done", d),  64'(done),  64'(m_done[d]));
      if (m_valid[d]) begin
         chk($sformatf("dut%0d_idx", d), 64'(idx), 64'(m_idx[d]));
         chk($sformatf("dut%0d_rk%0d", d, m_idx[d]), out, mkeys[d][m_idx[d]]);
      end
   endtask

   // single compare process: check current outputs, then advance the model
   always @(negedge clk) begin
      if (model_on) begin
         check_dut(0, a_busy, a_valid, a_done, int'(a_idx), 64'(a_out));
         check_dut(1, b_busy, b_valid, b_done, int'(b_idx), 64'(b_out));
      end
      model_step(0, rst, a_load, a_ready, 128'(a_key));
      model_step(1, rst, b_load, b_ready, 128'(b_key));
   end

   // ---------------- directed stimulus ----------------
   logic [63:0] cap [128];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // called just after the load edge; captures rk_out per cycle until done
   task automatic wait_done(input int d, input int budget, input int exp_at, input string nm);
      int c;
      bit seen;
      seen = 0;
      for (c = 0; c < budget; c++) begin
         @(negedge clk);
         if (c < 128) cap[c] = (d == 0) ? 64'(a_out) : 64'(b_out);
         if ((d == 0) ? a_done : b_done) begin
            seen = 1;
            break;
         end
      end
      chk({nm, "_done_seen"}, 64'(seen), 64'd1);
      if (seen && exp_at >= 0) chk({nm, "_done_at"}, 64'(c), 64'(exp_at));
   endtask

   initial begin
      int  cnt;
      int  t;
      bit  got;
      rst     = 1'b1;
      a_key   = '0;
      a_load  = 1'b0;
      a_ready = 1'b0;
      b_key   = '0;
      b_load  = 1'b0;
      b_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      model_on = 1'b1;

      @(negedge clk);
      chk("rst_valid", 64'(a_valid), 64'd0);
      chk("rst_busy",  64'(a_busy),  64'd0);
      chk("rst_done",  64'(a_done),  64'd0);
      chk("rst_idx",   64'(a_idx),   64'd0);
      chk("rst_out",   64'(a_out),   64'd0);
      chk("rst_b_valid", 64'(b_valid), 64'd0);
      tick();

      // SIMON64/96 reference key, consumer always ready
      a_key   = 96'h13121110_0B0A0908_03020100;
      a_ready = 1'b1;
      a_load  = 1'b1;
      tick();
      a_load  = 1'b0;
      wait_done(0, 100, 42, "s2");
      chk("s2_k0", cap[0], 64'h03020100);
      chk("s2_k1", cap[1], 64'h0B0A0908);
      chk("s2_k2", cap[2], 64'h13121110);
      chk("s2_k3", cap[3], 64'hFFAE9DCE);
      chk("s2_enc", encrypt(0, 64'h6f7220676e696c63), 64'h5ca2e27f111a8fc8);

      // back-to-back: load in the first idle cycle after done, all-zero key
      tick();
      a_key  = '0;
      a_load = 1'b1;
      tick();
      a_load = 1'b0;
      wait_done(0, 100, 42, "s3");
      chk("s3_k0", cap[0], 64'h0);
      chk("s3_k3", cap[3], 64'hFFFFFFFD);
      chk("s3_k4", cap[4], 64'h9FFFFFFC);

      // reset held three cycles in the middle of a run
      tick();
      a_key  = 96'h13121110_0B0A0908_03020100;
      a_load = 1'b1;
      tick();
      a_load = 1'b0;
      repeat (5) tick();
      chk("s1_idx_before", 64'(a_idx), 64'd5);
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("s1_valid", 64'(a_valid), 64'd0);
      chk("s1_idx",   64'(a_idx),   64'd0);
      chk("s1_busy",  64'(a_busy),  64'd0);
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (a_done) cnt++;
      end
      chk("s1_no_done", 64'(cnt), 64'd0);

      // random consumer stalls
      a_ready = 1'b0;
      a_load  = 1'b1;
      tick();
      a_load  = 1'b0;
      got = 0;
      for (int i = 0; i < 600 && !got; i++) begin
         a_ready = 1'($urandom_range(0, 1));
         tick();
         if (a_done) got = 1;
      end
      chk("s4_done_seen", 64'(got), 64'd1);
      a_ready = 1'b1;
      repeat (2) tick();

      // key_load during RUN (with a different key) and during DONE is ignored
      a_load = 1'b1;
      tick();
      a_load = 1'b0;
      t   = 0;
      got = 0;
      while (t < 200 && !got) begin
         tick();
         t++;
         a_load = 1'b0;
         if (t == 10) begin
            a_load = 1'b1;
            a_key  = 96'hDEADBEEF_CAFEF00D_12345678;
         end
         if (a_done) begin
            got    = 1;
            a_load = 1'b1;
         end
      end
      chk("s5_done_seen", 64'(got), 64'd1);
      chk("s5_done_at", 64'(t), 64'd42);
      tick();
      a_load = 1'b0;
      chk("s5_idle_valid", 64'(a_valid), 64'd0);
      chk("s5_idle_done",  64'(a_done),  64'd0);
      tick();
      chk("s5_idle_busy",  64'(a_busy),  64'd0);

      // SIMON32/64 configuration
      b_key   = 64'h1918_1110_0908_0100;
      b_ready = 1'b1;
      b_load  = 1'b1;
      tick();
      b_load  = 1'b0;
      wait_done(1, 100, 32, "s6");
      chk("s6_k0", cap[0], 64'h0100);
      chk("s6_k3", cap[3], 64'h1918);
      chk("s6_enc", encrypt(1, 64'h65656877), 64'hc69be9bb);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
